// File: rtl/multi_port_free_list_if.sv
// Port bundle for the multi-port physical-register free list.
// The rename stage drives the requests; the free list drives the registered results.
interface multi_port_free_list_if #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int ENQ_WIDTH     = 2,
    parameter int DEQ_WIDTH     = 2
);
    localparam int LP = $clog2(NUM_PHYS_REGS);
    localparam int DC = $clog2(DEQ_WIDTH + 1);

    // Handshake: an enqueue lane is offered when its Enqueue_IN bit is high and is accepted
    // unless the queue is full (a drop raises Overflow_OUT one cycle later). A dequeue of
    // DequeueCount_IN registers is all-or-nothing; DequeueResult_OUT and Data_OUT report the
    // outcome one cycle later, and Data_OUT keeps its value when nothing is handed out.
    logic [ENQ_WIDTH-1:0]    Enqueue_IN;
    logic [ENQ_WIDTH*LP-1:0] Data_IN;
    logic [DC-1:0]           DequeueCount_IN;
    logic                    DequeueResult_OUT;
    logic [DEQ_WIDTH*LP-1:0] Data_OUT;
    logic                    Checkpoint_IN;
    logic                    Restore_IN;
    logic [LP:0]             FreeCount_OUT;
    logic                    Overflow_OUT;

    modport master (
        output Enqueue_IN, Data_IN, DequeueCount_IN, Checkpoint_IN, Restore_IN,
        input  DequeueResult_OUT, Data_OUT, FreeCount_OUT, Overflow_OUT
    );

    modport slave (
        input  Enqueue_IN, Data_IN, DequeueCount_IN, Checkpoint_IN, Restore_IN,
        output DequeueResult_OUT, Data_OUT, FreeCount_OUT, Overflow_OUT
    );
endinterface

// File: rtl/multi_port_free_list.sv
// Circular free list of physical register numbers with multi-lane enqueue,
// all-or-nothing multi-register dequeue and a single head checkpoint.
module multi_port_free_list #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 32,
    parameter int ENQ_WIDTH     = 2,
    parameter int DEQ_WIDTH     = 2
) (
    input logic                 CLK,
    input logic                 RESET,
    multi_port_free_list_if.slave fl
);
    localparam int N     = NUM_PHYS_REGS;
    localparam int LP    = $clog2(NUM_PHYS_REGS);
    localparam int DC    = $clog2(DEQ_WIDTH + 1);
    localparam int FREE0 = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam logic [LP+1:0] N_W = (LP + 2)'(N);

    logic [LP:0]   head_q, head_d;
    logic [LP:0]   tail_q, tail_d;
    logic [LP:0]   ckpt_q, ckpt_d;
    logic [LP-1:0] queue_q [N];

    logic [ENQ_WIDTH-1:0] wr_en;
    logic [LP-1:0]        wr_idx  [ENQ_WIDTH];
    logic [LP-1:0]        wr_data [ENQ_WIDTH];

    logic [LP:0]             count;
    logic [DC-1:0]           dcnt;
    logic                    deq_ok;
    logic                    res_q, res_d;
    logic                    ovf_q, ovf_d;
    logic [DEQ_WIDTH*LP-1:0] dout_q, dout_d;

    // Pointers carry a wrap bit, so the difference is the occupancy even when full.
    assign count = tail_q - head_q;
    assign dcnt  = fl.DequeueCount_IN;

    always_comb begin : enq_logic
        logic [LP+1:0] acc;
        acc    = '0;
        wr_en  = '0;
        ovf_d  = 1'b0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            wr_idx[i]  = '0;
            wr_data[i] = fl.Data_IN[i*LP +: LP];
            if (fl.Enqueue_IN[i]) begin
                if (({1'b0, count} + acc) < N_W) begin
                    wr_en[i]  = 1'b1;
                    wr_idx[i] = tail_q[LP-1:0] + acc[LP-1:0];
                    acc       = acc + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
        tail_d = tail_q + acc[LP:0];
    end

    // Dequeue sees only start-of-cycle occupancy; a restore cancels it outright.
    always_comb begin : deq_logic
        deq_ok = !fl.Restore_IN && (dcnt != '0) && (int'(count) >= int'(dcnt));
        res_d  = deq_ok;
        dout_d = dout_q;
        if (deq_ok) begin
            for (int j = 0; j < DEQ_WIDTH; j++) begin
                dout_d[j*LP +: LP] = (j < int'(dcnt)) ? queue_q[head_q[LP-1:0] + LP'(j)] : '0;
            end
        end

        head_d = head_q;
        if (fl.Restore_IN) begin
            head_d = ckpt_q;
        end else if (deq_ok) begin
            head_d = head_q + (LP + 1)'(dcnt);
        end

        ckpt_d = ckpt_q;
        if (!fl.Restore_IN && fl.Checkpoint_IN) begin
            ckpt_d = head_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head_q <= '0;
            tail_q <= (LP + 1)'(FREE0);
            ckpt_q <= '0;
            res_q  <= 1'b0;
            ovf_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ckpt_q <= ckpt_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            dout_q <= dout_d;
        end
    end

    // Compaction guarantees the accepted lanes target distinct entries.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < N; k++) begin
                queue_q[k] <= (k < FREE0) ? LP'(NUM_ARCH_REGS + k) : '0;
            end
        end else begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (wr_en[i]) begin
                    queue_q[wr_idx[i]] <= wr_data[i];
                end
            end
        end
    end

    assign fl.DequeueResult_OUT = res_q;
    assign fl.Data_OUT          = dout_q;
    assign fl.FreeCount_OUT     = count;
    assign fl.Overflow_OUT      = ovf_q;
endmodule

// File: tb/tb_multi_port_free_list.sv
// Directed bench for multi_port_free_list at default parameters (64 phys, 32 arch, 2x2 lanes).
module tb_multi_port_free_list;
    localparam int NPR = 64;
    localparam int NAR = 32;
    localparam int EW  = 2;
    localparam int DW  = 2;
    localparam int LP  = 6;

    logic CLK = 1'b0;
    logic RESET;
    int   total = 0;
    int   bad   = 0;
    logic [LP-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    multi_port_free_list_if #(.NUM_PHYS_REGS(NPR), .ENQ_WIDTH(EW), .DEQ_WIDTH(DW)) fl ();

    multi_port_free_list #(
        .NUM_PHYS_REGS(NPR),
        .NUM_ARCH_REGS(NAR),
        .ENQ_WIDTH(EW),
        .DEQ_WIDTH(DW)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .fl   (fl)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2*LP-1:0] pk(input logic [LP-1:0] s0, input logic [LP-1:0] s1);
        return {s1, s0};
    endfunction

    task automatic drive_idle();
        fl.Enqueue_IN      = '0;
        fl.Data_IN         = '0;
        fl.DequeueCount_IN = '0;
        fl.Checkpoint_IN   = 1'b0;
        fl.Restore_IN      = 1'b0;
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge with inputs idle.
    task automatic cycle(input logic [1:0] enq, input logic [LP-1:0] d0, input logic [LP-1:0] d1,
                         input logic [1:0] dcnt, input logic ck, input logic rs);
        fl.Enqueue_IN      = enq;
        fl.Data_IN         = {d1, d0};
        fl.DequeueCount_IN = dcnt;
        fl.Checkpoint_IN   = ck;
        fl.Restore_IN      = rs;
        @(posedge CLK);
        #1;
        drive_idle();
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        #1;
        check("rst_result", 32'(fl.DequeueResult_OUT), 32'd0);
        check("rst_data",   32'(fl.Data_OUT),          32'd0);
        check("rst_ovf",    32'(fl.Overflow_OUT),      32'd0);
        check("rst_free",   32'(fl.FreeCount_OUT),     32'd32);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LP-1:0] e0, e1, v;
        RESET = 1'b0;
        drive_idle();
        @(posedge CLK);
        #1;
        do_reset();

        // Reset then drain to empty two at a time.
        for (int k = 0; k < 16; k++) begin
            cycle(2'b00, '0, '0, 2'd2, 1'b0, 1'b0);
            check("drain_data", 32'(fl.Data_OUT), 32'(pk(LP'(32 + 2*k), LP'(33 + 2*k))));
            check("drain_result", 32'(fl.DequeueResult_OUT), 32'd1);
            check("drain_free", 32'(fl.FreeCount_OUT), 32'(30 - 2*k));
        end
        cycle(2'b00, '0, '0, 2'd1, 1'b0, 1'b0);
        check("empty_result", 32'(fl.DequeueResult_OUT), 32'd0);
        check("empty_hold",   32'(fl.Data_OUT), 32'(pk(6'd62, 6'd63)));
        check("empty_free",   32'(fl.FreeCount_OUT), 32'd0);
        cycle(2'b00, '0, '0, 2'd0, 1'b0, 1'b0);
        check("zero_result", 32'(fl.DequeueResult_OUT), 32'd0);

        // Sparse lane into an empty queue: no same-cycle bypass.
        cycle(2'b10, 6'd0, 6'd5, 2'd1, 1'b0, 1'b0);
        check("sparse_result", 32'(fl.DequeueResult_OUT), 32'd0);
        check("sparse_free",   32'(fl.FreeCount_OUT), 32'd1);
        check("sparse_ovf",    32'(fl.Overflow_OUT), 32'd0);
        cycle(2'b00, '0, '0, 2'd2, 1'b0, 1'b0);
        check("short_result", 32'(fl.DequeueResult_OUT), 32'd0);
        check("short_free",   32'(fl.FreeCount_OUT), 32'd1);
        cycle(2'b00, '0, '0, 2'd1, 1'b0, 1'b0);
        check("sparse_data",   32'(fl.Data_OUT), 32'(pk(6'd5, 6'd0)));
        check("sparse_result2", 32'(fl.DequeueResult_OUT), 32'd1);

        // Checkpoint at head=0 with a same-cycle dequeue, dequeue 6 in total, then restore.
        do_reset();
        cycle(2'b00, '0, '0, 2'd2, 1'b1, 1'b0);
        check("ck_data", 32'(fl.Data_OUT), 32'(pk(6'd32, 6'd33)));
        cycle(2'b00, '0, '0, 2'd2, 1'b0, 1'b0);
        cycle(2'b00, '0, '0, 2'd2, 1'b0, 1'b0);
        check("ck_data3", 32'(fl.Data_OUT), 32'(pk(6'd36, 6'd37)));
        check("ck_free",  32'(fl.FreeCount_OUT), 32'd26);
        cycle(2'b01, 6'd40, 6'd0, 2'd2, 1'b0, 1'b1);
        check("rs_result", 32'(fl.DequeueResult_OUT), 32'd0);
        check("rs_hold",   32'(fl.Data_OUT), 32'(pk(6'd36, 6'd37)));
        check("rs_free",   32'(fl.FreeCount_OUT), 32'd33);
        cycle(2'b00, '0, '0, 2'd1, 1'b0, 1'b0);
        check("rs_data",   32'(fl.Data_OUT), 32'(pk(6'd32, 6'd0)));
        check("rs_free2",  32'(fl.FreeCount_OUT), 32'd32);

        // Restore wins over checkpoint; checkpoint must stay at 0.
        cycle(2'b00, '0, '0, 2'd0, 1'b1, 1'b1);
        check("prio_free", 32'(fl.FreeCount_OUT), 32'd33);
        cycle(2'b00, '0, '0, 2'd2, 1'b0, 1'b0);
        check("prio_data", 32'(fl.Data_OUT), 32'(pk(6'd32, 6'd33)));
        cycle(2'b00, '0, '0, 2'd0, 1'b0, 1'b1);
        check("prio_free2", 32'(fl.FreeCount_OUT), 32'd33);

        // Fill from 33 to 63, then offer two lanes: one accepted, one dropped.
        for (int k = 0; k < 15; k++) begin
            cycle(2'b11, LP'(2*k), LP'(2*k + 1), 2'd0, 1'b0, 1'b0);
        end
        check("fill_free", 32'(fl.FreeCount_OUT), 32'd63);
        check("fill_ovf",  32'(fl.Overflow_OUT), 32'd0);
        cycle(2'b11, 6'd10, 6'd11, 2'd0, 1'b0, 1'b0);
        check("ovf_pulse", 32'(fl.Overflow_OUT), 32'd1);
        check("ovf_free",  32'(fl.FreeCount_OUT), 32'd64);
        cycle(2'b00, '0, '0, 2'd0, 1'b0, 1'b0);
        check("ovf_clear", 32'(fl.Overflow_OUT), 32'd0);
        check("ovf_free2", 32'(fl.FreeCount_OUT), 32'd64);
        cycle(2'b01, 6'd12, 6'd0, 2'd0, 1'b0, 1'b0);
        check("full_ovf",  32'(fl.Overflow_OUT), 32'd1);
        check("full_free", 32'(fl.FreeCount_OUT), 32'd64);

        // Wrap-around: 70 cycles of 1-in/1-out against an expected-order queue.
        do_reset();
        exp_q.delete();
        for (int k = 0; k < NPR - NAR; k++) exp_q.push_back(LP'(NAR + k));
        for (int k = 0; k < 70; k++) begin
            v  = LP'((k * 7 + 3) % 64);
            e0 = exp_q.pop_front();
            cycle(2'b01, v, 6'd0, 2'd1, 1'b0, 1'b0);
            exp_q.push_back(v);
            check("wrap_data",   32'(fl.Data_OUT), 32'(pk(e0, 6'd0)));
            check("wrap_result", 32'(fl.DequeueResult_OUT), 32'd1);
        end
        check("wrap_free", 32'(fl.FreeCount_OUT), 32'd32);
        for (int k = 0; k < 16; k++) begin
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
            cycle(2'b00, '0, '0, 2'd2, 1'b0, 1'b0);
            check("wrap_drain", 32'(fl.Data_OUT), 32'(pk(e0, e1)));
        end
        check("wrap_empty", 32'(fl.FreeCount_OUT), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_port_free_list.md
MULTI_PORT_FREE_LIST -- requirements
Module: multi_port_free_list

Interface
REQ-001 SHALL have parameter NUM_PHYS_REGS, default 64: total physical registers; power of two, at least 4.
REQ-002 SHALL have parameter NUM_ARCH_REGS, default 32: registers mapped (not free) at reset; less than NUM_PHYS_REGS.
REQ-003 SHALL have parameter ENQ_WIDTH, default 2: enqueue lanes per cycle.
REQ-004 SHALL have parameter DEQ_WIDTH, default 2: maximum dequeues per cycle.
REQ-005 SHALL use LP = $clog2(NUM_PHYS_REGS) and DC = $clog2(DEQ_WIDTH+1) as derived widths.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port CLK, input, 1: clock, rising edge.
REQ-008 SHALL have port RESET, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port Enqueue_IN, input, ENQ_WIDTH: per-lane enqueue valid.
REQ-010 SHALL have port Data_IN, input, ENQ_WIDTH*LP: lane i register number at [i*LP +: LP].
REQ-011 SHALL have port DequeueCount_IN, input, DC: number of registers requested, 0..DEQ_WIDTH.
REQ-012 SHALL have port DequeueResult_OUT, output, 1: registered dequeue success.
REQ-013 SHALL have port Data_OUT, output, DEQ_WIDTH*LP: registered dequeued registers; slot j at [j*LP +: LP].
REQ-014 SHALL have port Checkpoint_IN, input, 1: snapshot the head pointer.
REQ-015 SHALL have port Restore_IN, input, 1: rewind head to the snapshot.
REQ-016 SHALL have port FreeCount_OUT, output, LP+1: current number of free entries.
REQ-017 SHALL have port Overflow_OUT, output, 1: one-cycle pulse when an enqueue lane was dropped.

Function
REQ-018 SHALL hold a circular queue of NUM_PHYS_REGS LP-bit entries; head and tail are LP+1 bits (wrap bit); count = tail - head modulo 2^(LP+1).
REQ-019 SHALL compute FreeCount_OUT combinationally from the registered pointers.
REQ-020 SHALL compact enqueue lanes in ascending lane order, writing the k-th valid lane to queue[(tail+k) mod N].
REQ-021 SHALL advance tail by the popcount of accepted lanes.
REQ-022 SHALL accept a lane only while count + accepted lanes so far < NUM_PHYS_REGS; excess lanes are dropped and Overflow_OUT pulses high the next cycle.
REQ-023 SHALL decide a dequeue against the count at the start of the cycle; same-cycle enqueues are not bypassed.
REQ-024 SHALL make dequeue all-or-nothing: when count >= DequeueCount_IN > 0, slots 0..DequeueCount_IN-1 of Data_OUT get queue[head..], head advances by DequeueCount_IN, and DequeueResult_OUT=1 the next cycle.
REQ-025 SHALL, when DequeueCount_IN exceeds count, leave head unchanged and drive DequeueResult_OUT=0 and Data_OUT held.
REQ-026 SHALL, when DequeueCount_IN=0, drive DequeueResult_OUT=0 next cycle and hold Data_OUT.
REQ-027 SHALL zero unused Data_OUT slots (index >= DequeueCount_IN) on a successful dequeue.
REQ-028 SHALL, on Checkpoint_IN, store the start-of-cycle head into the checkpoint register, regardless of a same-cycle dequeue.
REQ-029 SHALL, on Restore_IN, set head to the checkpoint, suppress any dequeue that cycle (DequeueResult_OUT=0), and still apply enqueues to tail.
REQ-030 SHALL give Restore_IN priority over Checkpoint_IN when both are asserted; the checkpoint is unchanged.
REQ-031 SHALL wrap all pointer arithmetic modulo 2^(LP+1); queue index = pointer[LP-1:0].

Reset
REQ-032 SHALL, while RESET=0 (asynchronous), set head=0, tail=NUM_PHYS_REGS-NUM_ARCH_REGS, checkpoint=0, and queue[i]=NUM_ARCH_REGS+i for i < NUM_PHYS_REGS-NUM_ARCH_REGS.
REQ-033 SHALL, while RESET=0, drive DequeueResult_OUT=0, Data_OUT=0, Overflow_OUT=0, FreeCount_OUT=NUM_PHYS_REGS-NUM_ARCH_REGS.
REQ-034 SHALL abandon any in-flight operation on reset assertion; the first edge after deassertion behaves as a normal cycle.

Verification (defaults)
REQ-035 SHALL be verified for reset followed by dequeue: reset, then DequeueCount_IN=2 -> next cycle Data_OUT slots {32,33}, DequeueResult_OUT=1, FreeCount_OUT=30.
REQ-036 SHALL be verified for drain to empty: 16 cycles of DequeueCount_IN=2 -> FreeCount_OUT=0, and a further request -> DequeueResult_OUT=0 with head unchanged.
REQ-037 SHALL be verified for sparse lanes at empty: with count=0, Enqueue_IN=2'b10, Data_IN lane1=5, DequeueCount_IN=1 -> same-cycle dequeue fails; the next cycle's dequeue returns 5.
REQ-038 SHALL be verified for checkpoint and restore: checkpoint at head=0, dequeue 6, then Restore_IN with Enqueue_IN=2'b01 (reg 40) -> FreeCount_OUT = 32+1 = 33, and the next dequeue returns 32.
REQ-039 SHALL be verified for overflow: from count=63, enqueue 2 lanes -> one accepted, FreeCount_OUT=64, Overflow_OUT pulses for exactly 1 cycle.
REQ-040 SHALL be verified for wrap-around: 70 cycles of interleaved 1-in/1-out -> pointers wrap past 63, with FIFO order preserved.
